// File: rtl/calc_pkg.sv
// calc_pkg: shared number, operator and button encodings for the calculator
package calc_pkg;
  localparam int NumDigits = 8;
  typedef struct packed {
    logic sign;
    logic error;
    logic [NumDigits-1:0][3:0] significand;
    logic [2:0] exponent;
  } num_t;
  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
  typedef enum logic [4:0] {
    B_0 = 5'd0, B_1 = 5'd1, B_2 = 5'd2, B_3 = 5'd3, B_4 = 5'd4,
    B_5 = 5'd5, B_6 = 5'd6, B_7 = 5'd7, B_8 = 5'd8, B_9 = 5'd9,
    B_DOT = 5'd10, B_ADD = 5'd11, B_SUB = 5'd12, B_MUL = 5'd13, B_DIV = 5'd14,
    B_EQ = 5'd15, B_CLEAR = 5'd16, B_MEM_ADD = 5'd17, B_MEM_SUB = 5'd18,
    B_MEM_RECALL = 5'd19, B_MEM_CLEAR = 5'd20, B_PERCENT = 5'd21, B_SQRT = 5'd22,
    B_NONE = 5'd23, B_UNKNOWN = 5'd31
  } active_button_t;
endpackage

// File: rtl/calc_ctrl.sv
// calc_ctrl: calculator key-entry FSM driving a shared ALU via valid/ready requests
module calc_ctrl
  import calc_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           button_valid_i,
  input  active_button_t button_i,
  output logic           alu_req_valid_o,
  input  logic           alu_req_ready_i,
  output op_t            alu_op_o,
  output num_t           alu_a_o,
  output num_t           alu_b_o,
  input  logic           alu_rsp_valid_i,
  input  num_t           alu_rsp_i,
  output num_t           display_o,
  output logic           mem_nonzero_o,
  output logic           busy_o
);
  typedef enum logic [2:0] {ENTRY_A, OP_WAIT, ENTRY_B, REQ, RSP, DRAIN, RESULT, ERROR} state_t;
  typedef enum logic [1:0] {K_FINAL, K_CHAIN, K_MEM} kind_t;
  state_t state_q, state_d, ret_q, ret_d, entry_state;
  kind_t kind_q, kind_d;
  num_t entry_q, entry_d, a_q, a_d, b_q, b_d, disp_q, disp_d, mem_q, mem_d, ra_q, ra_d, rb_q, rb_d;
  num_t base_e, key_e;
  op_t op_q, op_d, pend_q, pend_d, rop_q, rop_d, btn_op;
  logic [3:0] cnt_q, cnt_d, base_cnt, key_cnt;
  logic dot_q, dot_d, base_dot, key_dot;
  logic is_digit, is_dot, is_op, is_eq, is_clr, is_mem_op, is_mr, is_mc, fresh;
  assign is_digit = button_i <= B_9;
  assign is_dot = button_i == B_DOT;
  assign is_op = button_i inside {B_ADD, B_SUB, B_MUL, B_DIV};
  assign is_eq = button_i == B_EQ;
  assign is_clr = button_i == B_CLEAR;
  assign is_mem_op = button_i inside {B_MEM_ADD, B_MEM_SUB};
  assign is_mr = button_i == B_MEM_RECALL;
  assign is_mc = button_i == B_MEM_CLEAR;
  assign btn_op = button_i == B_ADD ? OP_ADD : button_i == B_SUB ? OP_SUB :
                  button_i == B_MUL ? OP_MUL : OP_DIV;
  assign fresh = state_q inside {OP_WAIT, RESULT};
  assign entry_state = state_q inside {OP_WAIT, ENTRY_B} ? ENTRY_B : ENTRY_A;
  assign alu_req_valid_o = state_q == REQ;
  assign alu_op_o = rop_q;
  assign alu_a_o = ra_q;
  assign alu_b_o = rb_q;
  assign display_o = state_q inside {ENTRY_A, ENTRY_B} ? entry_q : disp_q;
  assign mem_nonzero_o = |mem_q.significand;
  assign busy_o = state_q inside {REQ, RSP, DRAIN};
  always_comb begin
    base_e = fresh ? '0 : entry_q;
    base_cnt = fresh ? '0 : cnt_q;
    base_dot = fresh ? 1'b0 : dot_q;
    key_e = base_e;
    key_cnt = base_cnt;
    key_dot = base_dot;
    if (is_digit && base_cnt != 4'd8 && (base_cnt != 4'd0 || base_dot || button_i != B_0)) begin
      key_e.significand[3'd7 - base_cnt[2:0]] = button_i[3:0];
      key_cnt = base_cnt + 4'd1;
      if (!base_dot) key_e.exponent = base_cnt[2:0];
    end
    if (is_dot && !base_dot) begin
      key_dot = 1'b1;
      if (base_cnt == 4'd0) key_cnt = 4'd1;
    end
  end
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    kind_d = kind_q;
    entry_d = entry_q;
    cnt_d = cnt_q;
    dot_d = dot_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    pend_d = pend_q;
    disp_d = disp_q;
    mem_d = mem_q;
    ra_d = ra_q;
    rb_d = rb_q;
    rop_d = rop_q;
    if (button_valid_i && is_clr) begin
      entry_d = '0;
      cnt_d = '0;
      dot_d = 1'b0;
      a_d = '0;
      b_d = '0;
      op_d = OP_NONE;
      disp_d = '0;
      state_d = state_q inside {RSP, DRAIN} ? DRAIN : ENTRY_A;
    end else begin
      case (state_q)
        ENTRY_A, ENTRY_B, OP_WAIT, RESULT: if (button_valid_i) begin
          if (is_digit || is_dot) begin
            entry_d = key_e;
            cnt_d = key_cnt;
            dot_d = key_dot;
            state_d = entry_state;
          end
          if (is_mr) begin
            entry_d = mem_q;
            cnt_d = 4'd8;
            dot_d = 1'b1;
            state_d = entry_state;
          end
          if (is_mc) mem_d = '0;
          if (is_mem_op && state_q != OP_WAIT) begin
            ra_d = mem_q;
            rb_d = display_o;
            rop_d = button_i == B_MEM_ADD ? OP_ADD : OP_SUB;
            kind_d = K_MEM;
            ret_d = state_q;
            state_d = REQ;
          end
          if (is_op && state_q == ENTRY_B) begin
            b_d = entry_q;
            ra_d = a_q;
            rb_d = entry_q;
            rop_d = op_q;
            pend_d = btn_op;
            disp_d = entry_q;
            kind_d = K_CHAIN;
            state_d = REQ;
          end
          if (is_op && state_q != ENTRY_B) begin
            a_d = state_q == ENTRY_A ? entry_q : state_q == RESULT ? disp_q : a_q;
            disp_d = state_q == ENTRY_A ? entry_q : disp_q;
            op_d = btn_op;
            state_d = OP_WAIT;
          end
          if (is_eq && state_q inside {ENTRY_B, OP_WAIT}) begin
            b_d = state_q == ENTRY_B ? entry_q : a_q;
            ra_d = a_q;
            rb_d = b_d;
            rop_d = op_q;
            disp_d = state_q == ENTRY_B ? entry_q : disp_q;
            kind_d = K_FINAL;
            state_d = REQ;
          end
        end
        REQ: if (alu_req_ready_i) state_d = RSP;
        RSP: if (alu_rsp_valid_i) begin
          if (alu_rsp_i.error) begin
            disp_d = alu_rsp_i;
            state_d = ERROR;
          end else if (kind_q == K_MEM) begin
            mem_d = alu_rsp_i;
            state_d = ret_q;
          end else begin
            disp_d = alu_rsp_i;
            a_d = kind_q == K_CHAIN ? alu_rsp_i : a_q;
            op_d = kind_q == K_CHAIN ? pend_q : op_q;
            state_d = kind_q == K_CHAIN ? OP_WAIT : RESULT;
          end
        end
        DRAIN: if (alu_rsp_valid_i) state_d = ENTRY_A;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ENTRY_A;
      ret_q <= ENTRY_A;
      kind_q <= K_FINAL;
      entry_q <= '0;
      cnt_q <= '0;
      dot_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= OP_NONE;
      pend_q <= OP_NONE;
      disp_q <= '0;
      mem_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rop_q <= OP_NONE;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      kind_q <= kind_d;
      entry_q <= entry_d;
      cnt_q <= cnt_d;
      dot_q <= dot_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      mem_q <= mem_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      rop_q <= rop_d;
    end
  end
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: scoreboard bench for calc_ctrl with directed key sequences
module tb_calc_ctrl;
  import calc_pkg::*;
  logic clk = 0, rst_ni = 0, button_valid_i = 0, alu_req_ready_i = 0, alu_rsp_valid_i = 0;
  active_button_t button_i = B_NONE;
  num_t alu_rsp_i = '0;
  logic alu_req_valid_o, mem_nonzero_o, busy_o;
  op_t alu_op_o;
  num_t alu_a_o, alu_b_o, display_o;
  typedef struct {op_t op; num_t a; num_t b;} req_t;
  req_t exp_q[$];
  int checks = 0, errors = 0, n_hs = 0;
  calc_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .button_valid_i(button_valid_i), .button_i(button_i),
    .alu_req_valid_o(alu_req_valid_o), .alu_req_ready_i(alu_req_ready_i), .alu_op_o(alu_op_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_rsp_valid_i(alu_rsp_valid_i), .alu_rsp_i(alu_rsp_i),
    .display_o(display_o), .mem_nonzero_o(mem_nonzero_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  function automatic num_t mk(logic [31:0] sig, logic [2:0] e);
    num_t n;
    n = '0;
    n.significand = sig;
    n.exponent = e;
    return n;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_ni && alu_req_valid_o && alu_req_ready_i) begin
    req_t r;
    n_hs++;
    if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
    else begin
      r = exp_q.pop_front();
      chk("req_op", alu_op_o, r.op);
      chk("req_a", alu_a_o, r.a);
      chk("req_b", alu_b_o, r.b);
    end
  end
  task automatic press(active_button_t b);
    button_i = b;
    button_valid_i = 1;
    @(posedge clk); #1;
    button_valid_i = 0;
    button_i = B_NONE;
  endtask
  task automatic respond(num_t r);
    alu_rsp_i = r;
    alu_rsp_valid_i = 1;
    @(posedge clk); #1;
    alu_rsp_valid_i = 0;
  endtask
  task automatic expect_req(op_t o, num_t a, num_t b);
    exp_q.push_back('{o, a, b});
  endtask
  task automatic wait_hs();
    int start;
    start = n_hs;
    alu_req_ready_i = 1;
    for (int i = 0; i < 20 && n_hs == start; i++) begin
      @(posedge clk); #1;
    end
    alu_req_ready_i = 0;
    if (n_hs == start) chk("handshake_timeout", 0, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    num_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_display", display_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", alu_req_valid_o, 0);
    chk("rst_memnz", mem_nonzero_o, 0);
    rst_ni = 1;
    button_i = B_1;
    button_valid_i = 1;
    @(posedge clk); #1;
    button_valid_i = 0;
    chk("first_key", display_o, mk(32'h10000000, 0));
    press(B_2);
    press(B_ADD);
    press(B_3);
    chk("entry_b", display_o, mk(32'h30000000, 0));
    expect_req(OP_ADD, mk(32'h12000000, 1), mk(32'h30000000, 0));
    press(B_EQ);
    chk("busy_req", busy_o, 1);
    wait_hs();
    respond(mk(32'h15000000, 1));
    chk("result_disp", display_o, mk(32'h15000000, 1));
    chk("result_busy", busy_o, 0);
    press(B_CLEAR);
    for (int k = 1; k <= 9; k++) press(active_button_t'(k));
    chk("nine_digits", display_o, mk(32'h12345678, 7));
    press(B_DOT);
    press(B_5);
    chk("full_dot", display_o, mk(32'h12345678, 7));
    press(B_CLEAR);
    press(B_0);
    press(B_0);
    chk("lead_zero", display_o, 0);
    press(B_DOT);
    press(B_5);
    chk("dot_first", display_o, mk(32'h05000000, 0));
    press(B_CLEAR);
    press(B_5);
    press(B_ADD);
    expect_req(OP_ADD, mk(32'h50000000, 0), mk(32'h50000000, 0));
    press(B_EQ);
    wait_hs();
    respond(mk(32'h10000000, 1));
    chk("a_eq_b_disp", display_o, mk(32'h10000000, 1));
    press(B_CLEAR);
    press(B_2);
    press(B_MUL);
    press(B_3);
    expect_req(OP_MUL, mk(32'h20000000, 0), mk(32'h30000000, 0));
    press(B_ADD);
    for (int k = 0; k < 4; k++) begin
      chk("hold_valid", alu_req_valid_o, 1);
      chk("hold_a", alu_a_o, mk(32'h20000000, 0));
      chk("hold_b", alu_b_o, mk(32'h30000000, 0));
      @(posedge clk); #1;
    end
    wait_hs();
    respond(mk(32'h60000000, 0));
    chk("chain_disp", display_o, mk(32'h60000000, 0));
    chk("chain_busy", busy_o, 0);
    press(B_4);
    expect_req(OP_ADD, mk(32'h60000000, 0), mk(32'h40000000, 0));
    press(B_EQ);
    wait_hs();
    respond(mk(32'h10000000, 1));
    chk("chain_final", display_o, mk(32'h10000000, 1));
    press(B_CLEAR);
    press(B_1);
    press(B_ADD);
    press(B_2);
    press(B_EQ);
    chk("req_before_clr", alu_req_valid_o, 1);
    press(B_CLEAR);
    chk("clr_req_valid", alu_req_valid_o, 0);
    chk("clr_req_busy", busy_o, 0);
    press(B_1);
    press(B_ADD);
    press(B_1);
    expect_req(OP_ADD, mk(32'h10000000, 0), mk(32'h10000000, 0));
    press(B_EQ);
    wait_hs();
    press(B_CLEAR);
    chk("drain_busy", busy_o, 1);
    respond(mk(32'h20000000, 0));
    chk("drain_disp", display_o, 0);
    chk("drain_idle", busy_o, 0);
    press(B_3);
    chk("after_drain", display_o, mk(32'h30000000, 0));
    press(B_CLEAR);
    press(B_1);
    press(B_DIV);
    press(B_0);
    expect_req(OP_DIV, mk(32'h10000000, 0), 0);
    press(B_EQ);
    wait_hs();
    e = '0;
    e.error = 1;
    respond(e);
    chk("err_disp", display_o, e);
    press(B_7);
    chk("err_ignore", display_o, e);
    press(B_CLEAR);
    chk("err_clear", display_o, 0);
    press(B_7);
    chk("err_entry", display_o, mk(32'h70000000, 0));
    press(B_CLEAR);
    press(B_4);
    expect_req(OP_ADD, 0, mk(32'h40000000, 0));
    press(B_MEM_ADD);
    wait_hs();
    respond(mk(32'h40000000, 0));
    chk("mem_nz", mem_nonzero_o, 1);
    chk("mem_disp_kept", display_o, mk(32'h40000000, 0));
    press(B_CLEAR);
    chk("mem_kept", mem_nonzero_o, 1);
    press(B_MEM_RECALL);
    chk("mem_recall", display_o, mk(32'h40000000, 0));
    press(B_MEM_CLEAR);
    chk("mem_clear", mem_nonzero_o, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
